hcsr04_ranger: RTL and testbench

- Drives the HC-SR04 ultrasonic sensor: issues periodic trigger pulses and measures echo high-time in `clk` cycles.
- Publishes a held 32-bit `echo_duration` and a one-cycle `valid` strobe.
- Sits directly upstream of the distance-threshold LED/aux stage in the Tamagotchi ultrasonido path, which consumes `echo_duration` as raw cycle count (50 MHz, 2900 cycles/cm).

---
 rtl/hcsr04_ranger.sv | 192 +++++++++++++++++++
 tb/tb_hcsr04_ranger.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hcsr04_ranger.sv
// HC-SR04 ultrasonic ranger: periodic trigger pulses, echo high-time measured in clk cycles.
// Optional HCSR04_AVG4_EN: publish the mean of the last four results instead of the raw one.
module hcsr04_ranger #(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned TIMEOUT_CYCLES = 1_900_000,
  parameter int unsigned PERIOD_CYCLES  = 3_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        echo,
  output logic        trigger,
  output logic [31:0] echo_duration,
  output logic        valid,
  output logic        timeout,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StTrig, StWaitRise, StMeasure, StHoldoff} state_e;

  state_e      state_q, state_d;
  logic        echo_meta_q, echo_s_q, echo_s_prev_q;
  logic        echo_rise, echo_fall;
  logic [31:0] period_cnt_q, timeout_cnt_q, dur_cnt_q;
  logic        period_clr, timeout_hit;
  logic        res_load, res_to;
  logic [31:0] res_val;
  logic [31:0] echo_duration_q;
  logic        valid_q, timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_meta_q   <= 1'b0;
      echo_s_q      <= 1'b0;
      echo_s_prev_q <= 1'b0;
    end else begin
      echo_meta_q   <= echo;
      echo_s_q      <= echo_meta_q;
      echo_s_prev_q <= echo_s_q;
    end
  end

  assign echo_rise   = echo_s_q & ~echo_s_prev_q;
  assign echo_fall   = ~echo_s_q & echo_s_prev_q;
  // >= so a rise landing on the last WAIT_RISE cycle still times out in MEASURE
  assign timeout_hit = (timeout_cnt_q >= TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d    = state_q;
    period_clr = 1'b0;
    res_load   = 1'b0;
    res_to     = 1'b0;
    res_val    = '0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d    = StTrig;
          period_clr = 1'b1;
        end
      end
      StTrig: begin
        if (period_cnt_q == TRIG_CYCLES - 1) state_d = StWaitRise;
      end
      StWaitRise: begin
        if (echo_rise) begin
          state_d = StMeasure;
        end else if (timeout_hit) begin
          state_d  = StHoldoff;
          res_load = 1'b1;
          res_to   = 1'b1;
          res_val  = 32'hFFFF_FFFF;
        end
      end
      StMeasure: begin
        // A fall coinciding with the timeout is still a good result
        if (echo_fall) begin
          state_d  = StHoldoff;
          res_load = 1'b1;
          res_val  = dur_cnt_q;
        end else if (timeout_hit) begin
          state_d  = StHoldoff;
          res_load = 1'b1;
          res_to   = 1'b1;
          res_val  = 32'hFFFF_FFFF;
        end
      end
      StHoldoff: begin
        if (period_cnt_q == PERIOD_CYCLES - 1) begin
          if (enable) begin
            state_d    = StTrig;
            period_clr = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      period_cnt_q  <= '0;
      timeout_cnt_q <= '0;
      dur_cnt_q     <= '0;
    end else begin
      state_q <= state_d;

      if (period_clr) begin
        period_cnt_q <= '0;
      end else if (state_q != StIdle) begin
        period_cnt_q <= period_cnt_q + 32'd1;
      end

      if (state_q == StTrig) begin
        timeout_cnt_q <= '0;
      end else if (state_q == StWaitRise || state_q == StMeasure) begin
        timeout_cnt_q <= timeout_cnt_q + 32'd1;
      end

      if (state_q == StWaitRise && echo_rise) begin
        dur_cnt_q <= 32'd1;
      end else if (state_q == StMeasure && echo_s_q && dur_cnt_q != 32'hFFFF_FFFF) begin
        dur_cnt_q <= dur_cnt_q + 32'd1;
      end
    end
  end

`ifdef HCSR04_AVG4_EN
  logic [31:0] hist_q [4];
  logic        hist_full_q;
  logic        pend_q, pend_to_q;
  logic [33:0] hist_sum;

  assign hist_sum = {2'b00, hist_q[0]} + {2'b00, hist_q[1]} +
                    {2'b00, hist_q[2]} + {2'b00, hist_q[3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      hist_full_q     <= 1'b0;
      pend_q          <= 1'b0;
      pend_to_q       <= 1'b0;
      echo_duration_q <= '0;
      timeout_q       <= 1'b0;
      valid_q         <= 1'b0;
    end else begin
      pend_q  <= res_load;
      valid_q <= pend_q;
      if (res_load) begin
        pend_to_q   <= res_to;
        hist_full_q <= 1'b1;
        // First result after reset seeds the whole window
        if (!hist_full_q) begin
          for (int i = 0; i < 4; i++) hist_q[i] <= res_val;
        end else begin
          hist_q[0] <= res_val;
          hist_q[1] <= hist_q[0];
          hist_q[2] <= hist_q[1];
          hist_q[3] <= hist_q[2];
        end
      end
      if (pend_q) begin
        echo_duration_q <= hist_sum[33:2];
        timeout_q       <= pend_to_q;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_duration_q <= '0;
      timeout_q       <= 1'b0;
      valid_q         <= 1'b0;
    end else begin
      valid_q <= res_load;
      if (res_load) begin
        echo_duration_q <= res_val;
        timeout_q       <= res_to;
      end
    end
  end
`endif

  assign trigger       = (state_q == StTrig);
  assign busy          = (state_q != StIdle);
  assign echo_duration = echo_duration_q;
  assign valid         = valid_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_hcsr04_ranger.sv
// Scoreboard bench for hcsr04_ranger: random echo scenarios, reference model in plain arithmetic.
module tb_hcsr04_ranger;

  localparam int unsigned TRIG = 10;
  localparam int unsigned TMO  = 400;
  localparam int unsigned PER  = 600;
`ifdef HCSR04_AVG4_EN
  localparam int AVG_LAT = 1;
`else
  localparam int AVG_LAT = 0;
`endif
  localparam int K_PULSE = 0, K_NONE = 1, K_STUCK = 2, K_LONG = 3, K_DROP = 4;

  logic        clk, rst_n, enable, echo;
  logic        trigger, valid, timeout, busy;
  logic [31:0] echo_duration;

  hcsr04_ranger #(
    .TRIG_CYCLES   (TRIG),
    .TIMEOUT_CYCLES(TMO),
    .PERIOD_CYCLES (PER)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .echo         (echo),
    .trigger      (trigger),
    .echo_duration(echo_duration),
    .valid        (valid),
    .timeout      (timeout),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] dur;
    logic        to;
    longint      at;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] hist[$];
  int          tests = 0;
  int          fails = 0;
  longint      prev_rise = 0;
  bit          have_prev = 0;
  longint      exp_first = -1;
  logic        prev_valid = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic finish_sim();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: raw result, or mean of the last four (window seeded by the first result)
  task automatic push_exp(input logic [31:0] raw, input logic to, input longint at);
    exp_t   e;
    longint s;
`ifdef HCSR04_AVG4_EN
    if (hist.size() == 0) begin
      for (int i = 0; i < 4; i++) hist.push_back(raw);
    end else begin
      hist.push_front(raw);
      void'(hist.pop_back());
    end
    s = 0;
    foreach (hist[i]) s += longint'(hist[i]);
    e.dur = 32'(s / 4);
`else
    s     = 0;
    e.dur = raw;
`endif
    e.to = to;
    e.at = at;
    sb.push_back(e);
  endtask

  task automatic wait_trig(input logic level, output longint c);
    for (int i = 0; i < int'(PER) + 50; i++) begin
      tick();
      if (trigger == level) begin
        c = cyc;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL trigger_wait: trigger never reached %0d", level);
    finish_sim();
  endtask

  always @(negedge clk) begin
    if (rst_n && valid) begin
      check("valid_gap", longint'(prev_valid), 0);
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("echo_duration", longint'(echo_duration), longint'(e.dur));
        check("timeout_flag", longint'(timeout), longint'(e.to));
        check("valid_cycle", cyc, e.at);
      end
    end
    prev_valid <= valid;
  end

  // Echo is driven just after a clock edge, so synchronizer skew is zero and widths are exact
  task automatic measure(input int kind, input int d, input int w);
    longint r, f;
    wait_trig(1'b1, r);
    if (exp_first >= 0) check("trig_latency", r, exp_first);
    exp_first = -1;
    if (have_prev) check("trig_period", r - prev_rise, longint'(PER));
    prev_rise = r;
    have_prev = 1;
    if (kind == K_STUCK) echo = 1'b1;
    wait_trig(1'b0, f);
    check("trig_width", f - r, longint'(TRIG));
    case (kind)
      K_PULSE, K_DROP: begin
        repeat (d) tick();
        echo = 1'b1;
        if (kind == K_DROP) begin
          repeat (w / 2) tick();
          enable = 1'b0;
          repeat (w - w / 2) tick();
        end else begin
          repeat (w) tick();
        end
        echo = 1'b0;
        push_exp(32'(w), 1'b0, cyc + 3 + AVG_LAT);
      end
      K_NONE: begin
        push_exp(32'hFFFF_FFFF, 1'b1, f + TMO + AVG_LAT);
        repeat (TMO + 10) tick();
      end
      K_STUCK: begin
        push_exp(32'hFFFF_FFFF, 1'b1, f + TMO + AVG_LAT);
        repeat (TMO + 10) tick();
        echo = 1'b0;
      end
      default: begin
        repeat (d) tick();
        echo = 1'b1;
        push_exp(32'hFFFF_FFFF, 1'b1, f + TMO + AVG_LAT);
        repeat (int'(TMO) + 20 - d) tick();
        echo = 1'b0;
      end
    endcase
  endtask

  initial begin
    bit seen;
    rst_n  = 1'b0;
    enable = 1'b0;
    echo   = 1'b0;
    repeat (3) tick();
    check("rst_trigger", longint'(trigger), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_valid", longint'(valid), 0);
    check("rst_duration", longint'(echo_duration), 0);
    check("rst_timeout", longint'(timeout), 0);
    rst_n = 1'b1;
    repeat (2) tick();
    enable    = 1'b1;
    exp_first = cyc + 1;

    measure(K_PULSE, 20, 29);
    measure(K_PULSE, 20, 29);
    measure(K_PULSE, 20, 145);
    measure(K_PULSE, 20, 145);
    measure(K_NONE, 0, 0);
    measure(K_PULSE, 37, 29);
    measure(K_STUCK, 0, 0);
    measure(K_LONG, 30, 0);
    for (int i = 0; i < 16; i++) begin
      measure(int'($urandom_range(0, 3)), int'($urandom_range(5, 100)),
              int'($urandom_range(1, 250)));
    end

    // Enable dropped mid-measurement: result still arrives, then the ranger goes idle
    measure(K_DROP, 15, 60);
    seen = 1'b0;
    repeat (PER + 50) begin
      tick();
      if (trigger) seen = 1'b1;
    end
    check("no_retrigger", longint'(seen), 0);
    check("busy_after_drop", longint'(busy), 0);
    have_prev = 0;

    // Reset in the middle of MEASURE aborts without a result
    begin
      longint r, f;
      enable    = 1'b1;
      exp_first = cyc + 1;
      wait_trig(1'b1, r);
      check("trig_latency", r, exp_first);
      exp_first = -1;
      wait_trig(1'b0, f);
      repeat (10) tick();
      echo = 1'b1;
      repeat (20) tick();
      rst_n = 1'b0;
      #1;
      check("abort_trigger", longint'(trigger), 0);
      check("abort_busy", longint'(busy), 0);
      check("abort_valid", longint'(valid), 0);
      check("abort_duration", longint'(echo_duration), 0);
      check("abort_timeout", longint'(timeout), 0);
      hist.delete();
      echo = 1'b0;
      repeat (3) tick();
      rst_n     = 1'b1;
      exp_first = cyc + 1;
    end
    measure(K_PULSE, 20, 145);
    measure(K_NONE, 0, 0);
    enable = 1'b0;
    repeat (20) tick();
    check("scoreboard_drained", longint'(sb.size()), 0);
    finish_sim();
  end

endmodule
